// File: rtl/spi_target_pkg.sv
// Shared types and command codes for the SPI mode-0 register target.
package spi_target_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [BYTE_W-1:0] CMD_READ      = 8'h03;
  localparam logic [BYTE_W-1:0] CMD_WRITE     = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_ID        = 8'h9F;
  localparam logic [BYTE_W-1:0] CMD_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_target_regs_if.sv
// SPI pins plus local write-announce strobe of the SPI register target.
interface spi_target_regs_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              spi_cen;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output spi_cen, spi_sclk, spi_mosi,
    input  spi_miso, spi_miso_oe, wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  spi_cen, spi_sclk, spi_mosi,
    output spi_miso, spi_miso_oe, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by an edge detector for an asynchronous SPI pin.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise_c,
  output logic fall_c
);
  logic meta;
  logic sync;
  logic prev;

  // All stages reset low: a chip select already held low across reset produces no falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise_c = sync & ~prev;
  assign fall_c = ~sync & prev;
endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target serving a byte-wide register file (READ/WRITE/ID commands).
// Define SPI_TARGET_FAST_READ_EN to add the 0x0B fast-read command with 8 dummy clocks.
module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter logic [7:0]  ID_BYTE = 8'hA5
) (
  input logic clk,
  input logic rst,
  spi_target_regs_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      sh_in_q, sh_in_d;
  logic [BYTE_W-1:0]      sh_out_q, sh_out_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic                   id_q, id_d;
  logic                   is_wr_q, is_wr_d;
  logic                   miso_q, miso_d;
  logic                   oe_q, oe_d;
  logic                   wv_q, wv_d;
  logic [ADDR_W-1:0]      wa_q, wa_d;
  logic [BYTE_W-1:0]      wdat_q, wdat_d;
`ifdef SPI_TARGET_FAST_READ_EN
  logic                   fast_q, fast_d;
`endif

  logic [BYTE_W-1:0]      regs [DEPTH];
  logic                   regs_we;
  logic [BYTE_W-1:0]      byte_c;
  logic                   done_c;
  logic [BYTE_W-1:0]      rd_byte_c;

  logic cen_rise, cen_fall, sclk_rise, sclk_fall;
  logic mosi_meta, mosi_sync;

  spi_sync_edge u_cen_sync (
    .clk    (clk),
    .rst    (rst),
    .pin    (bus.spi_cen),
    .rise_c (cen_rise),
    .fall_c (cen_fall)
  );

  spi_sync_edge u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .pin    (bus.spi_sclk),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall)
  );

  // MOSI has the same two-stage latency as the SCLK edge it is sampled with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= bus.spi_mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign byte_c    = {sh_in_q[BYTE_W-2:0], mosi_sync};
  assign done_c    = sclk_rise && (bit_cnt_q == BIT_CNT_W'(7));
  assign rd_byte_c = id_q ? ID_BYTE : regs[ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_in_d   = sh_in_q;
    sh_out_d  = sh_out_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    is_wr_d   = is_wr_q;
    miso_d    = miso_q;
    oe_d      = 1'b0;
    wv_d      = 1'b0;
    wa_d      = wa_q;
    wdat_d    = wdat_q;
    regs_we   = 1'b0;
`ifdef SPI_TARGET_FAST_READ_EN
    fast_d    = fast_q;
`endif

    // A CS rise overrides any SCLK edge detected in the same cycle.
    if (cen_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else begin
      if (sclk_rise && (state_q != ST_IDLE)) begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        sh_in_d   = byte_c;
      end

      case (state_q)
        ST_IDLE: begin
          if (cen_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            id_d      = 1'b0;
            is_wr_d   = 1'b0;
`ifdef SPI_TARGET_FAST_READ_EN
            fast_d    = 1'b0;
`endif
          end
        end
        ST_CMD: begin
          if (done_c) begin
            case (byte_c)
              CMD_READ:  state_d = ST_ADDR;
              CMD_WRITE: begin
                state_d = ST_ADDR;
                is_wr_d = 1'b1;
              end
              CMD_ID: begin
                state_d = ST_READ;
                id_d    = 1'b1;
              end
`ifdef SPI_TARGET_FAST_READ_EN
              CMD_FAST_READ: begin
                state_d = ST_ADDR;
                fast_d  = 1'b1;
              end
`endif
              default:   state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (done_c) begin
            ptr_d   = byte_c[ADDR_W-1:0];
            state_d = is_wr_q ? ST_WRITE : ST_READ;
`ifdef SPI_TARGET_FAST_READ_EN
            if (fast_q) state_d = ST_DUMMY;
`endif
          end
        end
`ifdef SPI_TARGET_FAST_READ_EN
        ST_DUMMY: begin
          if (done_c) state_d = ST_READ;
        end
`endif
        ST_READ: begin
          // The fall that closes a byte (counter back at 0) fetches the next one.
          if (sclk_fall) begin
            if (bit_cnt_q == '0) begin
              miso_d   = rd_byte_c[BYTE_W-1];
              sh_out_d = {rd_byte_c[BYTE_W-2:0], 1'b0};
              if (!id_q) ptr_d = ptr_q + ADDR_W'(1);
            end else begin
              miso_d   = sh_out_q[BYTE_W-1];
              sh_out_d = {sh_out_q[BYTE_W-2:0], 1'b0};
            end
          end
        end
        ST_WRITE: begin
          if (done_c) begin
            regs_we = 1'b1;
            wv_d    = 1'b1;
            wa_d    = ptr_q;
            wdat_d  = byte_c;
            ptr_d   = ptr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end

    oe_d = (state_d == ST_READ);
    if (state_d != ST_READ) miso_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sh_in_q   <= '0;
      sh_out_q  <= '0;
      ptr_q     <= '0;
      id_q      <= 1'b0;
      is_wr_q   <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      wv_q      <= 1'b0;
      wa_q      <= '0;
      wdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_in_q   <= sh_in_d;
      sh_out_q  <= sh_out_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      is_wr_q   <= is_wr_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      wv_q      <= wv_d;
      wa_q      <= wa_d;
      wdat_q    <= wdat_d;
    end
  end

`ifdef SPI_TARGET_FAST_READ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fast_q <= 1'b0;
    else     fast_q <= fast_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          regs <= '{default: '0};
    else if (regs_we) regs[ptr_q] <= byte_c;
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.wr_valid    = wv_q;
  assign bus.wr_addr     = wa_q;
  assign bus.wr_data     = wdat_q;
endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: transaction table plus abort/reset/fast-read sequences.
module tb_spi_target_regs;
  localparam int unsigned HALF = 8;
  localparam int NV = 7;

  typedef struct {
    logic [47:0] tx;
    int          n;
    logic [47:0] rx;
    logic [5:0]  rx_mask;
    logic [5:0]  oe;
    int          n_wr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_target_regs_if #(.ADDR_W(4)) bus ();

  spi_target_regs #(.ADDR_W(4), .ID_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [11:0] wr_log [$];
  logic wv_prev = 1'b0;
  vec_t vecs [NV];

  // Log every write strobe and flag any strobe longer than one cycle.
  always @(negedge clk) begin
    if (bus.wr_valid) begin
      wr_log.push_back({bus.wr_addr, bus.wr_data});
      checks++;
      if (wv_prev) begin
        errors++;
        $display("FAIL wr_valid_width: got 2+ cycles high, expected 1");
      end
    end
    wv_prev = bus.wr_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cen = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    bus.spi_cen = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx, output logic oe_any, output logic oe_all);
    rx = 8'h00;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], bus.spi_miso};
      oe_any = oe_any | bus.spi_miso_oe;
      oe_all = oe_all & bus.spi_miso_oe;
      bus.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic read1(input string name, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] rx;
    logic oa, ol;
    cs_low();
    xfer_bits(8'h03, 8, rx, oa, ol);
    xfer_bits(addr, 8, rx, oa, ol);
    check({name, "_hdr_oe"}, {31'd0, oa}, 32'd0);
    xfer_bits(8'h00, 8, rx, oa, ol);
    check({name, "_rx"}, {24'd0, rx}, {24'd0, exp});
    check({name, "_oe"}, {31'd0, ol}, 32'd1);
    cs_high();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_miso"},  {31'd0, bus.spi_miso}, 32'd0);
    check({name, "_oe"},    {31'd0, bus.spi_miso_oe}, 32'd0);
    check({name, "_wv"},    {31'd0, bus.wr_valid}, 32'd0);
    check({name, "_waddr"}, {28'd0, bus.wr_addr}, 32'd0);
    check({name, "_wdata"}, {24'd0, bus.wr_data}, 32'd0);
  endtask

  initial begin
    logic [7:0] tx_b, rx_b;
    logic oa, ol;
    int base;

    vecs[0] = '{48'h020E11223300, 5, 48'h0, 6'b000000, 6'b000000, 3};
    vecs[1] = '{48'h030F00000000, 4, 48'h000022330000, 6'b001100, 6'b001100, 0};
    vecs[2] = '{48'h9F0000000000, 4, 48'h00A5A5A50000, 6'b001110, 6'b001110, 0};
    vecs[3] = '{48'h5500FF000000, 3, 48'h0, 6'b000000, 6'b000000, 0};
    vecs[4] = '{48'h030E00000000, 5, 48'h000011223300, 6'b011100, 6'b011100, 0};
    vecs[5] = '{48'h0201AB000000, 3, 48'h0, 6'b000000, 6'b000000, 1};
    vecs[6] = '{48'h030100000000, 3, 48'h0000AB000000, 6'b000100, 6'b000100, 0};

    bus.spi_cen  = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_outputs_zero("reset");

    for (int v = 0; v < NV; v++) begin
      base = wr_log.size();
      cs_low();
      for (int b = 0; b < vecs[v].n; b++) begin
        tx_b = vecs[v].tx[47-8*b -: 8];
        xfer_bits(tx_b, 8, rx_b, oa, ol);
        if (vecs[v].rx_mask[b])
          check($sformatf("v%0d_rx%0d", v, b), {24'd0, rx_b}, {24'd0, vecs[v].rx[47-8*b -: 8]});
        if (vecs[v].oe[b])
          check($sformatf("v%0d_oe%0d", v, b), {31'd0, ol}, 32'd1);
        else
          check($sformatf("v%0d_oe%0d", v, b), {31'd0, oa}, 32'd0);
      end
      cs_high();
      check($sformatf("v%0d_oe_after_cs", v), {31'd0, bus.spi_miso_oe}, 32'd0);
      check($sformatf("v%0d_nwr", v), wr_log.size() - base, vecs[v].n_wr);
    end

    if (wr_log.size() == 4) begin
      check("wr0", {20'd0, wr_log[0]}, {20'd0, 12'hE11});
      check("wr1", {20'd0, wr_log[1]}, {20'd0, 12'hF22});
      check("wr2", {20'd0, wr_log[2]}, {20'd0, 12'h033});
      check("wr3", {20'd0, wr_log[3]}, {20'd0, 12'h1AB});
    end else begin
      check("wr_log_size", wr_log.size(), 4);
    end

    // CS abort mid write byte: partial byte must not land.
    base = wr_log.size();
    cs_low();
    xfer_bits(8'h02, 8, rx_b, oa, ol);
    xfer_bits(8'h01, 8, rx_b, oa, ol);
    xfer_bits(8'h5A, 5, rx_b, oa, ol);
    cs_high();
    check("abort_nwr", wr_log.size() - base, 0);
    read1("abort_rd", 8'h01, 8'hAB);

    // Fast read: data only after the dummy byte; otherwise 0x0B is ignored.
    cs_low();
    xfer_bits(8'h0B, 8, rx_b, oa, ol);
    xfer_bits(8'h01, 8, rx_b, oa, ol);
    check("fast_hdr_oe", {31'd0, oa}, 32'd0);
    xfer_bits(8'h00, 8, rx_b, oa, ol);
    check("fast_dummy_oe", {31'd0, oa}, 32'd0);
`ifdef SPI_TARGET_FAST_READ_EN
    xfer_bits(8'h00, 8, rx_b, oa, ol);
    check("fast_rx", {24'd0, rx_b}, {24'd0, 8'hAB});
    check("fast_oe", {31'd0, ol}, 32'd1);
`else
    xfer_bits(8'h00, 8, rx_b, oa, ol);
    check("fast_off_oe", {31'd0, oa}, 32'd0);
`endif
    cs_high();

    // Reset in the middle of a write data byte.
    base = wr_log.size();
    cs_low();
    xfer_bits(8'h02, 8, rx_b, oa, ol);
    xfer_bits(8'h00, 8, rx_b, oa, ol);
    xfer_bits(8'hF0, 4, rx_b, oa, ol);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    xfer_bits(8'h50, 4, rx_b, oa, ol);
    check("midrst_tail_oe", {31'd0, oa}, 32'd0);
    cs_high();
    check("midrst_nwr", wr_log.size() - base, 0);
    read1("midrst_rd0", 8'h00, 8'h00);
    read1("midrst_rd1", 8'h01, 8'h00);
    read1("midrst_rdE", 8'h0E, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
